// File: rtl/cc_cond_unit_if.sv
// rtl/cc_cond_unit_if.sv - E-stage flag/condition bus between pipeline and cc_cond_unit
// Optional CC_PERF_EN adds the taken_cnt performance counter signal.
interface cc_cond_unit_if #(
    parameter int WIDTH = 64
);
    logic [3:0]       e_icode;
    logic [3:0]       e_ifun;
    logic             e_bubble;
    logic [WIDTH-1:0] alu_result;
    logic             alu_sign;
    logic             alu_over;
    logic [1:0]       m_stat;
    logic [1:0]       w_stat;
    logic             m_bubble;
    logic             e_cnd;
    logic             cc_zf;
    logic             cc_sf;
    logic             cc_of;
    logic             M_cnd;
    logic             frozen;
`ifdef CC_PERF_EN
    logic [31:0]      taken_cnt;
`endif

    modport master (
`ifdef CC_PERF_EN
        input  taken_cnt,
`endif
        output e_icode, e_ifun, e_bubble, alu_result, alu_sign, alu_over,
        output m_stat, w_stat, m_bubble,
        input  e_cnd, cc_zf, cc_sf, cc_of, M_cnd, frozen
    );

    modport slave (
`ifdef CC_PERF_EN
        output taken_cnt,
`endif
        input  e_icode, e_ifun, e_bubble, alu_result, alu_sign, alu_over,
        input  m_stat, w_stat, m_bubble,
        output e_cnd, cc_zf, cc_sf, cc_of, M_cnd, frozen
    );
endinterface

// File: rtl/cc_cond_unit.sv
// rtl/cc_cond_unit.sv - Y86-64 condition-code register, jXX/cmovXX evaluation and M_cnd stage
// Optional CC_PERF_EN adds a 32-bit taken-branch counter (taken_cnt).
module cc_cond_unit #(
    parameter int         WIDTH  = 64,
    parameter logic [3:0] OPQ    = 4'h6,
    parameter logic [3:0] JXX    = 4'h7,
    parameter logic [3:0] CMOVXX = 4'h2
) (
    input logic          clk,
    input logic          rst,
    cc_cond_unit_if.slave bus
);
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_FROZEN = 1'b1;
    localparam logic [1:0] STAT_AOK  = 2'b00;

    logic [0:0] state_q, state_d;
    logic       zf_q, zf_d;
    logic       sf_q, sf_d;
    logic       of_q, of_d;
    logic       m_cnd_q, m_cnd_d;
    logic       cond;
    logic       e_cnd;
    logic       cc_we;
    logic       lt;

    assign lt = sf_q ^ of_q;

    always_comb begin
        cond = 1'b0;
        case (bus.e_ifun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = lt | zf_q;
            4'h2:    cond = lt;
            4'h3:    cond = zf_q;
            4'h4:    cond = ~zf_q;
            4'h5:    cond = ~lt;
            4'h6:    cond = ~lt & ~zf_q;
            default: cond = 1'b0;
        endcase
    end

    // Evaluated from the stored flags only; an OPq in E does not forward to itself.
    assign e_cnd = ((bus.e_icode == JXX) || (bus.e_icode == CMOVXX)) && !bus.e_bubble && cond;

    assign cc_we = (state_q == ST_RUN) && (bus.e_icode == OPQ) && !bus.e_bubble &&
                   (bus.m_stat == STAT_AOK) && (bus.w_stat == STAT_AOK);

    always_comb begin
        zf_d    = zf_q;
        sf_d    = sf_q;
        of_d    = of_q;
        state_d = state_q;
        m_cnd_d = e_cnd;
        if (cc_we) begin
            zf_d = ~|bus.alu_result[WIDTH-1:0];
            sf_d = bus.alu_sign;
            of_d = bus.alu_over;
        end
        if ((state_q == ST_RUN) && (bus.w_stat != STAT_AOK))
            state_d = ST_FROZEN;
        if (bus.m_bubble || (state_q == ST_FROZEN))
            m_cnd_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            zf_q    <= 1'b1;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
            m_cnd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
            m_cnd_q <= m_cnd_d;
        end
    end

`ifdef CC_PERF_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ST_RUN) && (bus.e_icode == JXX) && e_cnd)
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 32'd0;
        else     cnt_q <= cnt_d;
    end

    assign bus.taken_cnt = cnt_q;
`endif

    assign bus.e_cnd  = e_cnd;
    assign bus.cc_zf  = zf_q;
    assign bus.cc_sf  = sf_q;
    assign bus.cc_of  = of_q;
    assign bus.M_cnd  = m_cnd_q;
    assign bus.frozen = (state_q == ST_FROZEN);
endmodule

// File: tb/tb_cc_cond_unit.sv
// tb/tb_cc_cond_unit.sv - directed self-checking bench for cc_cond_unit (CC_PERF_EN optional)
module tb_cc_cond_unit;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CMOVXX = 4'h2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    cc_cond_unit_if #(.WIDTH(64)) bus ();

    cc_cond_unit #(.WIDTH(64), .OPQ(OPQ), .JXX(JXX), .CMOVXX(CMOVXX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] res, input logic s, input logic o);
        bus.e_icode    = icode;
        bus.e_ifun     = ifun;
        bus.alu_result = res;
        bus.alu_sign   = s;
        bus.alu_over   = o;
        #1;
    endtask

    task automatic chk_cc(input string tag, input logic z, input logic s, input logic o);
        chk({tag, ".zf"}, {63'd0, bus.cc_zf}, {63'd0, z});
        chk({tag, ".sf"}, {63'd0, bus.cc_sf}, {63'd0, s});
        chk({tag, ".of"}, {63'd0, bus.cc_of}, {63'd0, o});
    endtask

    initial begin
        bus.e_bubble = 1'b0;
        bus.m_stat   = 2'b00;
        bus.w_stat   = 2'b00;
        bus.m_bubble = 1'b0;
        drive(OPQ, 4'h0, 64'd5, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        drive(4'h1, 4'h0, 64'd0, 1'b0, 1'b0);

        // reset state; OPq during reset must not have landed
        chk_cc("rst", 1'b1, 1'b0, 1'b0);
        chk("rst.m_cnd", {63'd0, bus.M_cnd}, 64'd0);
        chk("rst.frozen", {63'd0, bus.frozen}, 64'd0);
        drive(JXX, 4'h3, 64'd0, 1'b0, 1'b0);
        chk("t1.je", {63'd0, bus.e_cnd}, 64'd1);
        drive(JXX, 4'h4, 64'd0, 1'b0, 1'b0);
        chk("t1.jne", {63'd0, bus.e_cnd}, 64'd0);
        drive(4'h3, 4'h0, 64'd0, 1'b0, 1'b0);
        chk("t1.irmov_always", {63'd0, bus.e_cnd}, 64'd0);

        // OPq negative result
        drive(OPQ, 4'h0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0);
        chk("t2.no_fwd", {63'd0, bus.cc_sf}, 64'd0);
        tick();
        drive(JXX, 4'h2, 64'd0, 1'b0, 1'b0);
        chk_cc("t2", 1'b0, 1'b1, 1'b0);
        chk("t2.jl", {63'd0, bus.e_cnd}, 64'd1);
        drive(JXX, 4'h6, 64'd0, 1'b0, 1'b0);
        chk("t2.jg", {63'd0, bus.e_cnd}, 64'd0);
        drive(JXX, 4'h8, 64'd0, 1'b0, 1'b0);
        chk("t2.ifun8", {63'd0, bus.e_cnd}, 64'd0);
        drive(JXX, 4'h1, 64'd0, 1'b0, 1'b0);
        chk("t2.jle", {63'd0, bus.e_cnd}, 64'd1);
        drive(CMOVXX, 4'h5, 64'd0, 1'b0, 1'b0);
        chk("t2.cmovge", {63'd0, bus.e_cnd}, 64'd0);

        // m_stat exception suppresses the write but does not freeze
        drive(OPQ, 4'h0, 64'd0, 1'b0, 1'b1);
        bus.m_stat = 2'b10;
        tick();
        chk_cc("t3.mstat", 1'b0, 1'b1, 1'b0);
        chk("t3.frozen", {63'd0, bus.frozen}, 64'd0);
        bus.m_stat = 2'b00;
        tick();
        chk_cc("t3.write", 1'b1, 1'b0, 1'b1);

        // e_bubble OPq does not write
        bus.e_bubble = 1'b1;
        drive(OPQ, 4'h0, 64'd5, 1'b1, 1'b0);
        tick();
        bus.e_bubble = 1'b0;
        chk_cc("t3.ebub", 1'b1, 1'b0, 1'b1);

        // w_stat exception with OPq: no write, freeze
        bus.w_stat = 2'b01;
        drive(OPQ, 4'h0, 64'd5, 1'b1, 1'b0);
        tick();
        bus.w_stat = 2'b00;
        chk_cc("t4.wstat", 1'b1, 1'b0, 1'b1);
        chk("t4.frozen", {63'd0, bus.frozen}, 64'd1);
        tick();
        chk_cc("t4.frozen_opq", 1'b1, 1'b0, 1'b1);
        drive(CMOVXX, 4'h0, 64'd0, 1'b0, 1'b0);
        tick();
        chk("t4.m_cnd_frozen", {63'd0, bus.M_cnd}, 64'd0);
        chk("t4.still_frozen", {63'd0, bus.frozen}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4.rst_frozen", {63'd0, bus.frozen}, 64'd0);
        chk_cc("t4.rst", 1'b1, 1'b0, 1'b0);

        // M_cnd pipeline register
        bus.m_bubble = 1'b1;
        drive(CMOVXX, 4'h0, 64'd0, 1'b0, 1'b0);
        tick();
        chk("t5.mbub", {63'd0, bus.M_cnd}, 64'd0);
        bus.m_bubble = 1'b0;
        tick();
        chk("t5.mcnd", {63'd0, bus.M_cnd}, 64'd1);
        bus.e_bubble = 1'b1;
        #1;
        chk("t5.ebub_cnd", {63'd0, bus.e_cnd}, 64'd0);
        tick();
        chk("t5.ebub_mcnd", {63'd0, bus.M_cnd}, 64'd0);
        bus.e_bubble = 1'b0;

`ifdef CC_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6.cnt_rst", {32'd0, bus.taken_cnt}, 64'd0);
        drive(JXX, 4'h0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        drive(JXX, 4'h4, 64'd0, 1'b0, 1'b0);
        tick();
        chk("t6.cnt3", {32'd0, bus.taken_cnt}, 64'd3);
        drive(CMOVXX, 4'h0, 64'd0, 1'b0, 1'b0);
        tick();
        chk("t6.cmov_nocount", {32'd0, bus.taken_cnt}, 64'd3);
        bus.w_stat = 2'b01;
        drive(JXX, 4'h0, 64'd0, 1'b0, 1'b0);
        tick();
        bus.w_stat = 2'b00;
        chk("t6.cnt_freeze_edge", {32'd0, bus.taken_cnt}, 64'd4);
        tick();
        tick();
        chk("t6.cnt_frozen", {32'd0, bus.taken_cnt}, 64'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
